param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter WIDTH, default 16, register bit width; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter COUNT, default 4, number of registers; SHALL be 2..16.
REQ-003 Parameter SELW, default $clog2(COUNT), read-select width.
REQ-004 Clock  input  1  rising-edge clock; the block's only clock.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 I  input  WIDTH  shared load data.
REQ-007 E  input  COUNT  per-register enable; bit k enables register k.
REQ-008 FunSel  input  3  operation applied to every enabled register.
REQ-009 OutASel  input  SELW  read port A register index.
REQ-010 OutBSel  input  SELW  read port B register index.
REQ-011 OutA  output  WIDTH  contents of register OutASel.
REQ-012 OutB  output  WIDTH  contents of register OutBSel.
REQ-013 Wrap  output  1  one-cycle pulse: an inc/dec hit a numeric boundary on the previous edge.

Function
REQ-014 Each register R[k] SHALL update only on the rising Clock edge with E[k]=1; with E[k]=0 it holds.
REQ-015 FunSel encodings SHALL be:
  - 000: R-1.
  - 001: R+1.
  - 010: R=I.
  - 011: R=0.
  - 100: R={zeros, I[7:0]}.
  - 101: R[7:0]=I[7:0], rest held.
  - 110: R[15:8]=I[7:0], rest held.
  - 111: R={sign-extend I[7], I[7:0]} to WIDTH.
REQ-016 Several E bits set SHALL apply the same FunSel to each enabled register independently, each using its own current value.
REQ-017 OutA/OutB SHALL be combinational reads of current register state; a write SHALL become visible in the cycle after its edge, with no same-cycle bypass.
REQ-018 OutASel/OutBSel values ≥ COUNT SHALL drive all zeros.
REQ-019 Without saturation, decrement from 0 SHALL give all ones and increment from all ones SHALL give 0, modulo 2^WIDTH.
REQ-020 Wrap SHALL be registered and asserted for exactly one cycle after any edge where an enabled register executes 000 at value 0 or 001 at all ones.
REQ-021 Wrap SHALL be the OR over all enabled registers; it SHALL be 0 after every other edge.
REQ-022 No operation SHALL take more than one cycle; there is no busy or stall state.

Reset
REQ-023 Reset=0 SHALL immediately, independent of Clock, force every register to 0 and Wrap to 0.
REQ-024 While Reset=0, E and FunSel SHALL be ignored.
REQ-025 Reset asserted in the same cycle as an operation SHALL win; the operation is lost.
REQ-026 After Reset deasserts, the first rising edge SHALL execute normally.

Configuration
REQ-027 Macro REGFILE_SATURATE_EN SHALL select inc/dec boundary behaviour.
REQ-028 With REGFILE_SATURATE_EN defined, 000 at 0 SHALL hold 0 and 001 at all ones SHALL hold all ones; Wrap still pulses per REQ-020.
REQ-029 Without REGFILE_SATURATE_EN, inc/dec SHALL wrap per REQ-019; all other encodings are identical in both builds.

Verification
REQ-030 Reset low mid-cycle with R[2]=0x1234 -> all outputs 0 before the next edge; holding E=1111 with FunSel=001 under reset -> registers stay 0.
REQ-031 E=0101, FunSel=010, I=0xA5C3 -> R0=R2=0xA5C3 and R1=R3 unchanged; OutASel=2 shows 0xA5C3 one cycle after the edge, never in the same cycle.
REQ-032 R1=0x1234, FunSel=101 I=0x00EF -> 0x12EF; then 110 I=0x0077 -> 0x77EF; then 111 I=0x0080 -> 0xFF80; then 100 I=0xFF80 -> 0x0080.
REQ-033 R0=0, E=0001, FunSel=000 -> default build gives R0=0xFFFF with Wrap=1 for one cycle; saturate build gives R0=0 with Wrap=1 for one cycle.
REQ-034 R3=0xFFFF, E=1000, FunSel=001 twice -> default build gives 0x0000 then 0x0001, Wrap high only after the first edge; saturate build gives 0xFFFF both times, Wrap high after each edge.
REQ-035 WIDTH=32, COUNT=8, OutBSel=7, then OutBSel driven out of range, FunSel=111 I=0x7F on R7 -> R7=0x0000007F; any out-of-range select reads 0.

Source files
------------

// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: load data, per-register enables, operation select,
// two read ports and the wrap pulse. Directions are named from the register file's side.
interface param_register_file_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned COUNT = 4,
  parameter int unsigned SELW  = $clog2(COUNT)
);
  logic [WIDTH-1:0] i_data;
  logic [COUNT-1:0] i_en;
  logic [2:0]       i_fun_sel;
  logic [SELW-1:0]  i_outa_sel;
  logic [SELW-1:0]  i_outb_sel;
  logic [WIDTH-1:0] o_outa;
  logic [WIDTH-1:0] o_outb;
  logic             o_wrap;

  modport master (
    output i_data, i_en, i_fun_sel, i_outa_sel, i_outb_sel,
    input  o_outa, o_outb, o_wrap
  );

  modport slave (
    input  i_data, i_en, i_fun_sel, i_outa_sel, i_outb_sel,
    output o_outa, o_outb, o_wrap
  );
endinterface

// File: rtl/param_register_file.sv
// COUNT x WIDTH register file: one shared operation applied to every enabled register, two
// combinational read ports, registered inc/dec boundary pulse. Define REGFILE_SATURATE_EN to
// make inc/dec saturate at the boundary instead of wrapping modulo 2^WIDTH.
module param_register_file #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned COUNT = 4,
  parameter int unsigned SELW  = $clog2(COUNT)
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  param_register_file_if.slave io_bus
);

  typedef enum logic [2:0] {
    OpDec    = 3'b000,
    OpInc    = 3'b001,
    OpLoad   = 3'b010,
    OpClr    = 3'b011,
    OpLoadLo = 3'b100,
    OpWrLo   = 3'b101,
    OpWrHi   = 3'b110,
    OpLoadSx = 3'b111
  } op_e;

  localparam logic [WIDTH-1:0] One     = WIDTH'(1);
  localparam logic [WIDTH-1:0] AllOnes = '1;

  logic [WIDTH-1:0] r_regs   [COUNT];
  logic [WIDTH-1:0] w_regs_d [COUNT];
  logic [COUNT-1:0] w_hit;
  logic             r_wrap;
  op_e              w_op;
  logic [WIDTH-1:0] w_outa;
  logic [WIDTH-1:0] w_outb;

  assign w_op = op_e'(io_bus.i_fun_sel);

  // Each enabled register computes from its own current value; disabled ones hold.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < int'(COUNT); k++) begin
      w_regs_d[k] = r_regs[k];
    end
    for (int k = 0; k < int'(COUNT); k++) begin
      if (io_bus.i_en[k]) begin
        unique case (w_op)
          OpDec: begin
            w_hit[k] = (r_regs[k] == '0);
`ifdef REGFILE_SATURATE_EN
            w_regs_d[k] = w_hit[k] ? r_regs[k] : r_regs[k] - One;
`else
            w_regs_d[k] = r_regs[k] - One;
`endif
          end
          OpInc: begin
            w_hit[k] = (r_regs[k] == AllOnes);
`ifdef REGFILE_SATURATE_EN
            w_regs_d[k] = w_hit[k] ? r_regs[k] : r_regs[k] + One;
`else
            w_regs_d[k] = r_regs[k] + One;
`endif
          end
          OpLoad:   w_regs_d[k] = io_bus.i_data;
          OpClr:    w_regs_d[k] = '0;
          OpLoadLo: w_regs_d[k] = {{(WIDTH-8){1'b0}}, io_bus.i_data[7:0]};
          OpWrLo:   w_regs_d[k][7:0] = io_bus.i_data[7:0];
          OpWrHi:   w_regs_d[k][15:8] = io_bus.i_data[7:0];
          OpLoadSx: w_regs_d[k] = {{(WIDTH-8){io_bus.i_data[7]}}, io_bus.i_data[7:0]};
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(COUNT); k++) begin
        r_regs[k] <= '0;
      end
      r_wrap <= 1'b0;
    end else begin
      for (int k = 0; k < int'(COUNT); k++) begin
        r_regs[k] <= w_regs_d[k];
      end
      r_wrap <= |w_hit;
    end
  end

  // Selects that match no register fall through to zero.
  always_comb begin
    w_outa = '0;
    w_outb = '0;
    for (int k = 0; k < int'(COUNT); k++) begin
      if (io_bus.i_outa_sel == SELW'(k)) begin
        w_outa = r_regs[k];
      end
      if (io_bus.i_outb_sel == SELW'(k)) begin
        w_outb = r_regs[k];
      end
    end
  end

  assign io_bus.o_outa = w_outa;
  assign io_bus.o_outb = w_outb;
  assign io_bus.o_wrap = r_wrap;

endmodule

// File: tb/tb_param_register_file.sv
// Randomized bench for param_register_file: a 16x4 and a 32x8 (4-bit selects) instance are
// compared against an arithmetic reference model after every edge.
module tb_param_register_file;

  localparam int unsigned W0 = 16;
  localparam int unsigned C0 = 4;
  localparam int unsigned W1 = 32;
  localparam int unsigned C1 = 8;
  localparam int unsigned S1 = 4;
`ifdef REGFILE_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #20 clk = ~clk;

  param_register_file_if #(.WIDTH(W0), .COUNT(C0)) bus0 ();
  param_register_file_if #(.WIDTH(W1), .COUNT(C1), .SELW(S1)) bus1 ();

  param_register_file #(.WIDTH(W0), .COUNT(C0)) dut0 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus0)
  );

  param_register_file #(.WIDTH(W1), .COUNT(C1), .SELW(S1)) dut1 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus1)
  );

  longint unsigned m0 [C0];
  longint unsigned m1 [C1];
  bit              mw0;
  bit              mw1;
  int              n_tests;
  int              n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned next_val(input longint unsigned r, input int op,
                                               input longint unsigned d, input int w,
                                               output bit hit);
    longint unsigned mask;
    longint unsigned lo;
    longint unsigned res;
    mask = (64'd1 << w) - 64'd1;
    lo   = d & 64'hff;
    hit  = 1'b0;
    case (op)
      0: if (r == 0) begin hit = 1'b1; res = Sat ? 64'd0 : mask; end else res = r - 1;
      1: if (r == mask) begin hit = 1'b1; res = Sat ? mask : 64'd0; end else res = r + 1;
      2: res = d & mask;
      3: res = 0;
      4: res = lo;
      5: res = (r & ~64'hff) | lo;
      6: res = (r & ~64'hff00) | (lo << 8);
      default: res = (lo >= 128) ? ((mask & ~64'hff) | lo) : lo;
    endcase
    return res;
  endfunction

  function automatic longint unsigned exp1(input int k);
    return (k < int'(C1)) ? m1[k] : 64'd0;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < int'(C0); k++) m0[k] = 0;
    for (int k = 0; k < int'(C1); k++) m1[k] = 0;
    mw0 = 1'b0;
    mw1 = 1'b0;
  endtask

  // Predict from the inputs present before the edge, then clock and commit.
  task automatic step();
    longint unsigned n0 [C0];
    longint unsigned n1 [C1];
    bit h, w0, w1;
    w0 = 1'b0;
    w1 = 1'b0;
    for (int k = 0; k < int'(C0); k++) begin
      n0[k] = m0[k];
      if (bus0.i_en[k]) begin
        n0[k] = next_val(m0[k], int'(bus0.i_fun_sel), longint'(bus0.i_data), W0, h);
        w0 |= h;
      end
    end
    for (int k = 0; k < int'(C1); k++) begin
      n1[k] = m1[k];
      if (bus1.i_en[k]) begin
        n1[k] = next_val(m1[k], int'(bus1.i_fun_sel), longint'(bus1.i_data), W1, h);
        w1 |= h;
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      clear_model();
    end else begin
      m0  = n0;
      m1  = n1;
      mw0 = w0;
      mw1 = w1;
    end
    #1;
  endtask

  task automatic op(input logic [C0-1:0] e0, input logic [2:0] f0, input logic [W0-1:0] d0,
                    input logic [C1-1:0] e1, input logic [2:0] f1, input logic [W1-1:0] d1);
    bus0.i_en = e0; bus0.i_fun_sel = f0; bus0.i_data = d0;
    bus1.i_en = e1; bus1.i_fun_sel = f1; bus1.i_data = d1;
    step();
    bus0.i_en = '0;
    bus1.i_en = '0;
  endtask

  // Sweeps every select value on both ports of both instances.
  task automatic check_all(input string tag);
    for (int k = 0; k < 16; k++) begin
      if (k < int'(C0)) begin
        bus0.i_outa_sel = 2'(k);
        bus0.i_outb_sel = 2'(int'(C0) - 1 - k);
      end
      bus1.i_outa_sel = 4'(k);
      bus1.i_outb_sel = 4'(15 - k);
      #1;
      if (k < int'(C0)) begin
        check_eq($sformatf("%s a0[%0d]", tag, k), bus0.o_outa, m0[k]);
        check_eq($sformatf("%s b0[%0d]", tag, int'(C0) - 1 - k), bus0.o_outb,
                 m0[int'(C0) - 1 - k]);
      end
      check_eq($sformatf("%s a1[%0d]", tag, k), bus1.o_outa, exp1(k));
      check_eq($sformatf("%s b1[%0d]", tag, 15 - k), bus1.o_outb, exp1(15 - k));
    end
    check_eq({tag, " wrap0"}, bus0.o_wrap, mw0);
    check_eq({tag, " wrap1"}, bus1.o_wrap, mw1);
  endtask

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 32'hffff_ffff;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] pick_fun();
    if ($urandom_range(0, 1) == 1) return 3'($urandom_range(0, 1));
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus0.i_en = '0; bus0.i_fun_sel = '0; bus0.i_data = '0;
    bus0.i_outa_sel = '0; bus0.i_outb_sel = '0;
    bus1.i_en = '0; bus1.i_fun_sel = '0; bus1.i_data = '0;
    bus1.i_outa_sel = '0; bus1.i_outb_sel = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Distinct contents so holds are observable.
    for (int k = 0; k < int'(C0); k++) op(4'(1 << k), 3'd2, 16'($urandom), 8'h0, 3'd0, 32'h0);
    for (int k = 0; k < int'(C1); k++) op(4'h0, 3'd0, 16'h0, 8'(1 << k), 3'd2, $urandom);
    check_all("preload");

    // Write is not visible until after its edge.
    bus0.i_outa_sel = 2'd2;
    bus0.i_en = 4'b0101; bus0.i_fun_sel = 3'd2; bus0.i_data = 16'ha5c3;
    #1;
    check_eq("same_cycle_a", bus0.o_outa, m0[2]);
    step();
    bus0.i_en = '0;
    check_eq("next_cycle_a", bus0.o_outa, 16'ha5c3);
    check_all("load_0101");

    // Asynchronous reset mid-cycle, and enables ignored while it is held.
    op(4'b0100, 3'd2, 16'h1234, 8'h0, 3'd0, 32'h0);
    bus0.i_outa_sel = 2'd2;
    #1;
    check_eq("r2_before_reset", bus0.o_outa, 16'h1234);
    #5;
    rst_n = 1'b0;
    clear_model();
    bus0.i_en = 4'hf; bus0.i_fun_sel = 3'd1;
    bus1.i_en = 8'hff; bus1.i_fun_sel = 3'd1;
    #1;
    check_all("async_reset");
    step();
    step();
    check_all("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    bus0.i_en = '0;
    bus1.i_en = '0;
    bus0.i_outa_sel = 2'd0;
    op(4'b0001, 3'd1, 16'h0, 8'h0, 3'd0, 32'h0);
    check_eq("first_edge_inc", bus0.o_outa, 16'h0001);

    // Byte-lane operations on R1.
    bus0.i_outa_sel = 2'd1;
    op(4'b0010, 3'd2, 16'h1234, 8'h0, 3'd0, 32'h0);
    op(4'b0010, 3'd5, 16'h00ef, 8'h0, 3'd0, 32'h0);
    check_eq("wr_lo", bus0.o_outa, 16'h12ef);
    op(4'b0010, 3'd6, 16'h0077, 8'h0, 3'd0, 32'h0);
    check_eq("wr_hi", bus0.o_outa, 16'h77ef);
    op(4'b0010, 3'd7, 16'h0080, 8'h0, 3'd0, 32'h0);
    check_eq("load_sx", bus0.o_outa, 16'hff80);
    op(4'b0010, 3'd4, 16'hff80, 8'h0, 3'd0, 32'h0);
    check_eq("load_lo", bus0.o_outa, 16'h0080);

    // Decrement at zero.
    bus0.i_outa_sel = 2'd0;
    op(4'b0001, 3'd3, 16'h0, 8'h0, 3'd0, 32'h0);
    op(4'b0001, 3'd0, 16'h0, 8'h0, 3'd0, 32'h0);
    check_eq("dec_zero", bus0.o_outa, Sat ? 16'h0000 : 16'hffff);
    check_eq("dec_zero_wrap", bus0.o_wrap, 1'b1);
    op(4'b0000, 3'd0, 16'h0, 8'h0, 3'd0, 32'h0);
    check_eq("dec_zero_wrap_drop", bus0.o_wrap, 1'b0);

    // Increment at all ones, twice.
    bus0.i_outa_sel = 2'd3;
    op(4'b1000, 3'd2, 16'hffff, 8'h0, 3'd0, 32'h0);
    op(4'b1000, 3'd1, 16'h0, 8'h0, 3'd0, 32'h0);
    check_eq("inc_max_1", bus0.o_outa, Sat ? 16'hffff : 16'h0000);
    check_eq("inc_max_1_wrap", bus0.o_wrap, 1'b1);
    op(4'b1000, 3'd1, 16'h0, 8'h0, 3'd0, 32'h0);
    check_eq("inc_max_2", bus0.o_outa, Sat ? 16'hffff : 16'h0001);
    check_eq("inc_max_2_wrap", bus0.o_wrap, Sat);
    check_all("inc_dec_bounds");

    // Wide instance: sign extension on R7 and out-of-range selects.
    bus1.i_outb_sel = 4'd7;
    op(4'h0, 3'd0, 16'h0, 8'h80, 3'd7, 32'h7f);
    check_eq("r7_sx_pos", bus1.o_outb, 32'h0000_007f);
    op(4'h0, 3'd0, 16'h0, 8'h80, 3'd7, 32'h80);
    check_eq("r7_sx_neg", bus1.o_outb, 32'hffff_ff80);
    for (int s = int'(C1); s < 16; s++) begin
      bus1.i_outb_sel = 4'(s);
      #1;
      check_eq($sformatf("oor_sel[%0d]", s), bus1.o_outb, 32'h0);
    end
    check_all("wide");

    for (int i = 0; i < 200; i++) begin
      d = pick_data();
      op(4'($urandom), pick_fun(), d[15:0], 8'($urandom), pick_fun(), pick_data());
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
